// File: rtl/alu_issue_if.sv
// Handshake and ALU-side bundle for alu_issue_stage: request port, ALU operand/result wires, result port.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_y;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic        out_carry;
    logic        out_err;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_y, alu_carry, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_carry, out_err
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_y, alu_carry, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_carry, out_err
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Registers operands onto an external combinational ALU, captures its result one cycle later
// and buffers results in an in-order FIFO drained over a valid/ready port.
//   state | meaning
//   IDLE  | no op on the ALU
//   EXEC  | registered operands on the ALU, result captured at the next edge
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [17:0]   mem [DEPTH];

    logic          exec;
    logic          accept;
    logic          push;
    logic          pop;
    logic          sel_legal;
    logic [CW:0]   occupancy;
    logic [17:0]   push_data;
    logic [17:0]   head;

    assign exec      = (state == EXEC);
    // The op sitting in EXEC already owns a FIFO slot, so a push can never hit a full FIFO.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, exec};
    assign bus.in_ready = rst_n && (occupancy < DEPTH_W);
    assign accept    = bus.in_valid && bus.in_ready;

    // Illegal selects leave the ALU floating, so its outputs must never reach the FIFO.
    assign sel_legal = (bus.alu_sel <= 4'd2);
    assign push_data = sel_legal ? {bus.alu_y, bus.alu_carry, 1'b0} : {16'h0000, 1'b0, 1'b1};
    assign push      = exec;

    assign bus.out_valid = (count != '0);
    assign pop       = bus.out_valid && bus.out_ready;
    assign head      = mem[rd_ptr];
    assign bus.out_y     = bus.out_valid ? head[17:2] : 16'h0000;
    assign bus.out_carry = bus.out_valid ? head[1]    : 1'b0;
    assign bus.out_err   = bus.out_valid ? head[0]    : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus.alu_a   <= 16'h0000;
            bus.alu_b   <= 16'h0000;
            bus.alu_sel <= 4'h0;
        end else if (accept) begin
            state       <= EXEC;
            bus.alu_a   <= bus.in_a;
            bus.alu_b   <= bus.in_b;
            bus.alu_sel <= bus.in_sel;
        end else begin
            state       <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule
